// File: rtl/predecode_pkg.sv
// Shared predecode definitions: opcode classifier functions and the forced-break opcode.
// Pure combinational helpers, no state.
// Used by the queue classifier and by the legacy single-byte predecode stage.
package predecode_pkg;

  // Opcode injected on the instruction register when an interrupt forces a break.
  localparam logic [7:0] BRK_OPCODE = 8'h00;

  // Implied (one-byte) opcode form.
  function automatic logic pd_implied(input logic [7:0] b);
    return b[3] & ~b[2] & ~b[0];
  endfunction

  // Active-low: 0 when the opcode completes in two cycles.
  function automatic logic pd_two_cycle_n(input logic [7:0] b);
    logic m1;
    logic m2;
    logic m3;
    logic imp;
    m1  = ~b[4] & b[3] & ~b[2] & b[0];
    m2  = b[7] & ~b[4] & ~b[3] & ~b[2] & ~b[0];
    m3  = ~b[7] & ~b[4] & b[3] & ~b[2] & ~b[1] & ~b[0];
    imp = pd_implied(b);
    return ~(m1 | m2 | (imp & ~m3));
  endfunction

endpackage

// File: rtl/predecode_classify.sv
// Combinational opcode classifier used on the queue push path.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is stored.
module predecode_classify
  import predecode_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] opc,
  output logic              imp,
  output logic              tc_n
);

  // Only the low byte carries decode information.
  assign imp  = pd_implied(opc[7:0]);
  assign tc_n = pd_two_cycle_n(opc[7:0]);

endmodule

// File: rtl/predecode_queue.sv
// Predecode queue: buffers opcode bytes with push-time flags, presents the head to the IR.
// Latency: one edge from push to head; interrupt-forced BRK is combinational from aic_n/fetch.
// Backpressure: pd_ready = ~full from registered count; no pass-through when full.
module predecode_queue
  import predecode_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_1,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pd,
  input  logic              pd_valid,
  output logic              pd_ready,
  input  logic              flush,
  input  logic              aic_n,
  input  logic              fetch,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              implied,
  output logic              tz_pre_n,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  imp_q, imp_d;
  logic [DEPTH-1:0]  tcn_q, tcn_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic force_brk;
  logic pd_imp;
  logic pd_tcn;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign force_brk = ~aic_n & fetch;
  assign push      = pd_valid & ~full;
  // A forced break holds the head so the interrupted opcode is replayed later.
  assign pop       = fetch & aic_n & ~empty;

  predecode_classify #(
    .DATA_W (DATA_W)
  ) u_classify (
    .opc  (pd),
    .imp  (pd_imp),
    .tc_n (pd_tcn)
  );

  // Next-state: flush wins over push/pop; otherwise push and pop are independent.
  always_comb begin
    data_d   = data_q;
    imp_d    = imp_q;
    tcn_d    = tcn_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = pd;
        imp_d[wr_ptr_q]  = pd_imp;
        tcn_d[wr_ptr_q]  = pd_tcn;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers; reset empties the queue immediately.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      imp_q    <= '0;
      tcn_q    <= '1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      imp_q    <= imp_d;
      tcn_q    <= tcn_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head presentation: forced BRK overrides, an empty queue shows a cleared IR.
  always_comb begin
    ir       = '0;
    implied  = 1'b0;
    tz_pre_n = 1'b1;
    ir_valid = 1'b0;
    if (force_brk) begin
      ir       = DATA_W'(BRK_OPCODE);
      ir_valid = 1'b1;
    end else if (!empty) begin
      ir       = data_q[rd_ptr_q];
      implied  = imp_q[rd_ptr_q];
      tz_pre_n = tcn_q[rd_ptr_q];
      ir_valid = 1'b1;
    end
  end

  assign pd_ready = ~full;
  assign count    = count_q;

endmodule

// File: tb/tb_predecode_queue.sv
// Self-checking bench for predecode_queue: directed literal checks plus randomized
// traffic compared every cycle against a queue-based behavioural model.
module tb_predecode_queue;

  localparam int DEPTH = 4;

  logic       clk_1 = 1'b0;
  logic       rst_n;
  logic [7:0] pd;
  logic       pd_valid;
  logic       pd_ready;
  logic       flush;
  logic       aic_n;
  logic       fetch;
  logic [7:0] ir;
  logic       ir_valid;
  logic       implied;
  logic       tz_pre_n;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: the queue contents as a plain list of bytes.
  logic [7:0] mq[$];

  predecode_queue #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_1    (clk_1),
    .rst_n    (rst_n),
    .pd       (pd),
    .pd_valid (pd_valid),
    .pd_ready (pd_ready),
    .flush    (flush),
    .aic_n    (aic_n),
    .fetch    (fetch),
    .ir       (ir),
    .ir_valid (ir_valid),
    .implied  (implied),
    .tz_pre_n (tz_pre_n),
    .count    (count)
  );

  always #5 clk_1 = ~clk_1;

  // Opcode classes written as bit-pattern matches over masked bytes.
  function automatic logic m_imp(input logic [7:0] b);
    return (b & 8'h0D) == 8'h08;
  endfunction

  function automatic logic m_tcn(input logic [7:0] b);
    logic p1, p2, p3;
    p1 = (b & 8'h1D) == 8'h09;
    p2 = (b & 8'h9D) == 8'h80;
    p3 = (b & 8'h9F) == 8'h08;
    return !(p1 || p2 || (m_imp(b) && !p3));
  endfunction

  // Model state update: same edge semantics as the queue's rules.
  always @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      bit do_push, do_pop;
      do_push = pd_valid && (mq.size() < DEPTH);
      do_pop  = fetch && aic_n && (mq.size() > 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(pd);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against what the model says it must be now.
  task automatic compare_model();
    logic [7:0] e_ir;
    logic       e_imp, e_tz, e_vld;
    if (!aic_n && fetch) begin
      e_ir = 8'h00; e_imp = 1'b0; e_tz = 1'b1; e_vld = 1'b1;
    end else if (mq.size() == 0) begin
      e_ir = 8'h00; e_imp = 1'b0; e_tz = 1'b1; e_vld = 1'b0;
    end else begin
      e_ir = mq[0]; e_imp = m_imp(mq[0]); e_tz = m_tcn(mq[0]); e_vld = 1'b1;
    end
    chk("m_ir",       32'(ir),       32'(e_ir));
    chk("m_implied",  32'(implied),  32'(e_imp));
    chk("m_tz_pre_n", 32'(tz_pre_n), 32'(e_tz));
    chk("m_ir_valid", 32'(ir_valid), 32'(e_vld));
    chk("m_count",    32'(count),    32'(mq.size()));
    chk("m_pd_ready", 32'(pd_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic drive(input logic pv, input logic [7:0] b, input logic fl,
                       input logic an, input logic ft);
    @(negedge clk_1);
    pd_valid = pv;
    pd       = b;
    flush    = fl;
    aic_n    = an;
    fetch    = ft;
  endtask

  // One full cycle: drive, check pre-edge outputs, take the edge, check post-edge.
  task automatic cyc(input logic pv, input logic [7:0] b, input logic fl,
                     input logic an, input logic ft);
    drive(pv, b, fl, an, ft);
    #1 compare_model();
    @(posedge clk_1);
    #1 compare_model();
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic push(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    pd       = 8'h00;
    pd_valid = 1'b0;
    flush    = 1'b0;
    aic_n    = 1'b1;
    fetch    = 1'b0;

    #2;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_pd_ready", 32'(pd_ready), 32'd1);
    chk("rst_tz_pre_n", 32'(tz_pre_n), 32'd1);
    chk("rst_ir",       32'(ir),       32'h00);
    @(negedge clk_1);
    rst_n = 1'b1;

    // Push-to-head latency and classification of LDA #.
    push(8'hA9);
    chk("a9_ir",      32'(ir),       32'hA9);
    chk("a9_implied", 32'(implied),  32'd0);
    chk("a9_tz",      32'(tz_pre_n), 32'd0);
    chk("a9_count",   32'(count),    32'd1);
    // Push NOP while popping LDA.
    cyc(1'b1, 8'hEA, 1'b0, 1'b1, 1'b1);
    chk("ea_ir",      32'(ir),       32'hEA);
    chk("ea_implied", 32'(implied),  32'd1);
    chk("ea_tz",      32'(tz_pre_n), 32'd0);
    pop();
    chk("empty_vld",  32'(ir_valid), 32'd0);

    // Fill with PHP, DEX, LDY #, AND #, then try a fifth byte.
    push(8'h08); push(8'hCA); push(8'hA0); push(8'h29);
    chk("php_ir",     32'(ir),       32'h08);
    chk("php_imp",    32'(implied),  32'd1);
    chk("php_tz",     32'(tz_pre_n), 32'd1);
    chk("full_cnt",   32'(count),    32'd4);
    chk("full_rdy",   32'(pd_ready), 32'd0);
    push(8'h55);
    chk("full_hold",  32'(count),    32'd4);
    // Full with a pop: the offered byte is still refused.
    cyc(1'b1, 8'h66, 1'b0, 1'b1, 1'b1);
    chk("dex_ir",     32'(ir),       32'hCA);
    chk("dex_tz",     32'(tz_pre_n), 32'd0);
    chk("nopass_cnt", 32'(count),    32'd3);
    // Push with each pop across the pointer wrap.
    cyc(1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    chk("ldy_ir",     32'(ir),       32'hA0);
    chk("ldy_tz",     32'(tz_pre_n), 32'd0);
    cyc(1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    chk("and_ir",     32'(ir),       32'h29);
    chk("and_tz",     32'(tz_pre_n), 32'd0);
    cyc(1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    chk("wrap_ir",    32'(ir),       32'h11);
    chk("wrap_cnt",   32'(count),    32'd3);
    pop(); pop(); pop();
    chk("drain_cnt",  32'(count),    32'd0);

    // Forced BRK does not consume the head.
    push(8'h20); push(8'hA9);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    chk("brk_ir",     32'(ir),       32'h00);
    chk("brk_imp",    32'(implied),  32'd0);
    chk("brk_tz",     32'(tz_pre_n), 32'd1);
    chk("brk_vld",    32'(ir_valid), 32'd1);
    @(posedge clk_1);
    #1;
    chk("brk_cnt",    32'(count),    32'd2);
    idle();
    chk("jsr_ir",     32'(ir),       32'h20);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    #1;
    chk("jsr_fetch",  32'(ir),       32'h20);
    @(posedge clk_1);
    #1;
    chk("after_jsr",  32'(ir),       32'hA9);

    // Flush beats a same-cycle push and pop.
    push(8'h01); push(8'h02);
    cyc(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
    chk("fl_cnt",     32'(count),    32'd0);
    chk("fl_vld",     32'(ir_valid), 32'd0);
    idle();
    chk("fl_drop",    32'(count),    32'd0);

    // Asynchronous reset mid-cycle with entries queued.
    push(8'hC8); push(8'h88);
    @(negedge clk_1);
    pd_valid = 1'b0;
    fetch    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_cnt",     32'(count),    32'd0);
    chk("ar_vld",     32'(ir_valid), 32'd0);
    chk("ar_ir",      32'(ir),       32'h00);
    chk("ar_rdy",     32'(pd_ready), 32'd1);
    compare_model();
    @(negedge clk_1);
    rst_n = 1'b1;
    idle();
    chk("ar_after",   32'(count),    32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic pv, fl, an, ft;
      pv = ($urandom_range(0, 99) < 65);
      fl = ($urandom_range(0, 99) < 4);
      an = ($urandom_range(0, 99) >= 12);
      ft = ($urandom_range(0, 99) < 45);
      cyc(pv, 8'($urandom), fl, an, ft);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
